// File: rtl/uart_tx.sv
// UART transmitter: pops one word from a show-ahead FIFO per frame and serialises it
// LSB first with one start bit and a configurable stop period, timed by a baud x16 Tick.
module uart_tx #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned STOP_TICKS = 16
) (
    input  logic                 Clock,
    input  logic                 ResetN,
    input  logic                 Tick,
    input  logic                 FifoEmpty,
    input  logic [DATA_BITS-1:0] FifoData,
    output logic                 FifoRead,
    output logic                 Tx,
    output logic                 Busy,
    output logic                 Done
);

    // Tick counter widens only when the stop period needs more than 16 ticks.
    localparam int unsigned TickW = (STOP_TICKS > 16) ? $clog2(STOP_TICKS) : 4;

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e               state_q, state_d;
    logic [TickW-1:0]     tick_cnt_q, tick_cnt_d;
    logic [2:0]           bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        tx_d       = tx_q;
        done_d     = 1'b0;
        case (state_q)
            StIdle: begin
                // Tick in the pop cycle is deliberately ignored.
                if (!FifoEmpty) begin
                    shreg_d    = FifoData;
                    tick_cnt_d = '0;
                    bit_cnt_d  = '0;
                    tx_d       = 1'b0;
                    state_d    = StStart;
                end
            end
            StStart: begin
                if (Tick) begin
                    if (tick_cnt_q == TickW'(15)) begin
                        tick_cnt_d = '0;
                        bit_cnt_d  = '0;
                        tx_d       = shreg_q[0];
                        state_d    = StData;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TickW'(1);
                    end
                end
            end
            StData: begin
                if (Tick) begin
                    if (tick_cnt_q == TickW'(15)) begin
                        tick_cnt_d = '0;
                        shreg_d    = shreg_q >> 1;
                        if (bit_cnt_q == 3'(DATA_BITS - 1)) begin
                            tx_d    = 1'b1;
                            state_d = StStop;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                            tx_d      = shreg_q[1];
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TickW'(1);
                    end
                end
            end
            StStop: begin
                if (Tick) begin
                    if (tick_cnt_q == TickW'(STOP_TICKS - 1)) begin
                        tick_cnt_d = '0;
                        done_d     = 1'b1;
                        state_d    = StIdle;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TickW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge Clock) begin
        if (!ResetN) begin
            state_q    <= StIdle;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Pop strobe is gated by reset so a pending word waits until reset is released.
    assign FifoRead = ResetN && (state_q == StIdle) && !FifoEmpty;
    assign Tx       = tx_q;
    assign Busy     = busy_q;
    assign Done     = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: a tick-count frame model checked every cycle,
// directed frames pinned with literal expectations, then randomized traffic and resets.
module tb_uart_tx;

    localparam int DB    = 8;
    localparam int ST    = 16;
    localparam int FRAME = 16 * (1 + DB) + ST;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0;
    logic       fifo_empty = 1'b1;
    logic [7:0] fifo_data = 8'h00;
    logic       fifo_read, tx, busy, done;
    logic       fifo_empty32 = 1'b1;
    logic       fifo_read32, tx32, busy32, done32;

    always #5 clk = ~clk;

    uart_tx #(.DATA_BITS(DB), .STOP_TICKS(ST)) u_dut (
        .Clock(clk), .ResetN(rst_n), .Tick(tick), .FifoEmpty(fifo_empty),
        .FifoData(fifo_data), .FifoRead(fifo_read), .Tx(tx), .Busy(busy), .Done(done)
    );

    uart_tx #(.DATA_BITS(8), .STOP_TICKS(32)) u_dut32 (
        .Clock(clk), .ResetN(rst_n), .Tick(tick), .FifoEmpty(fifo_empty32),
        .FifoData(8'h81), .FifoRead(fifo_read32), .Tx(tx32), .Busy(busy32), .Done(done32)
    );

    int         cyc = 0;
    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] fifo[$];
    bit         m_busy = 1'b0;
    int         m_ticks = 0;
    logic [7:0] m_data = 8'h00;
    bit         exp_done = 1'b0;
    int         tick_per = 1;
    bit         rst_next = 1'b0;
    bit         empty32_next = 1'b1;
    int         pops = 0, dones = 0, last_pop = 0, last_done = 0;
    int         pops32 = 0, dones32 = 0, last_pop32 = 0, last_done32 = 0;
    logic       tx_log[$];
    logic       tx32_log[$];

    // Line level t ticks into a frame: start bit, data LSB first, then stop.
    function automatic logic line_bit(input logic [7:0] d, input int t);
        if (t < 16) return 1'b0;
        if (t < 16 + 16 * DB) return d[(t - 16) / 16];
        return 1'b1;
    endfunction

    function automatic logic [7:0] frame_byte(input int e0, input int per, input bit sel32);
        logic [7:0] b;
        for (int k = 0; k < 8; k++) begin
            b[k] = sel32 ? tx32_log[e0 + (24 + 16 * k) * per] : tx_log[e0 + (24 + 16 * k) * per];
        end
        return b;
    endfunction

    function automatic int lows(input int a, input int b, input bit sel32);
        int n = 0;
        for (int i = a; i <= b; i++) begin
            if ((sel32 ? tx32_log[i] : tx_log[i]) == 1'b0) n++;
        end
        return n;
    endfunction

    function automatic int cnt(input int sel);
        case (sel)
            0: return pops;
            1: return dones;
            2: return pops32;
            default: return dones32;
        endcase
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            if (n_err <= 40) $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: update the model at the edge, drive inputs just after it, compare at negedge.
    task automatic step();
        @(posedge clk);
        exp_done = 1'b0;
        if (!rst_n) begin
            m_busy = 1'b0;
        end else if (!m_busy) begin
            if (!fifo_empty) begin
                m_busy  = 1'b1;
                m_ticks = 0;
                m_data  = fifo_data;
                fifo.delete(0);
            end
        end else if (tick) begin
            m_ticks++;
            if (m_ticks == FRAME) begin
                m_busy   = 1'b0;
                exp_done = 1'b1;
            end
        end
        cyc++;
        #1;
        rst_n        = rst_next;
        tick         = (tick_per == 0) ? ($urandom_range(0, 2) == 0) : (cyc % tick_per == 0);
        fifo_empty   = (fifo.size() == 0);
        fifo_data    = fifo_empty ? 8'($urandom) : fifo[0];
        fifo_empty32 = empty32_next;
        @(negedge clk);
        check("Tx", int'(tx), int'(m_busy ? line_bit(m_data, m_ticks) : 1'b1));
        check("Busy", int'(busy), int'(m_busy));
        check("Done", int'(done), int'(exp_done));
        check("FifoRead", int'(fifo_read), int'(rst_n && !m_busy && !fifo_empty));
        if (fifo_read) begin pops++; last_pop = cyc; end
        if (done) begin dones++; last_done = cyc; end
        if (fifo_read32) begin pops32++; last_pop32 = cyc; empty32_next = 1'b1; end
        if (done32) begin dones32++; last_done32 = cyc; end
        tx_log.push_back(tx);
        tx32_log.push_back(tx32);
    endtask

    task automatic wait_for(input int sel, input int target, input int budget, input string name);
        int n = 0;
        while (cnt(sel) < target && n < budget) begin
            step();
            n++;
        end
        check(name, int'(cnt(sel) >= target), 1);
    endtask

    initial begin
        int p0, d0, e0, e1, ea, eb, da, r;
        tx_log.push_back(1'b1);
        tx32_log.push_back(1'b1);
        repeat (3) step();
        check("rst_tx", int'(tx), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_read", int'(fifo_read), 0);
        rst_next = 1'b1;
        repeat (2) step();

        // 0x55 with Tick every cycle
        p0 = pops; d0 = dones;
        fifo.push_back(8'h55);
        wait_for(1, d0 + 1, 400, "t1_timeout");
        e0 = last_pop + 1;
        check("t1_done_latency", last_done - e0, 160);
        check("t1_pops", pops - p0, 1);
        check("t1_start", int'(tx_log[e0 + 8]), 0);
        check("t1_byte", int'(frame_byte(e0, 1, 1'b0)), 8'h55);
        check("t1_stop", int'(tx_log[e0 + 152]), 1);
        repeat (5) step();

        // back-to-back 0xA3, 0x0F
        p0 = pops; d0 = dones;
        fifo.push_back(8'hA3);
        fifo.push_back(8'h0F);
        wait_for(0, p0 + 1, 50, "t2_pop_timeout");
        ea = last_pop + 1;
        wait_for(1, d0 + 1, 400, "t2_done1_timeout");
        da = last_done;
        check("t2_gap", last_pop - da, 0);
        eb = last_pop + 1;
        wait_for(1, d0 + 2, 400, "t2_done2_timeout");
        check("t2_pops", pops - p0, 2);
        check("t2_idle_high", int'(tx_log[da]), 1);
        check("t2_start2", int'(tx_log[eb]), 0);
        check("t2_byte1", int'(frame_byte(ea, 1, 1'b0)), 8'hA3);
        check("t2_byte2", int'(frame_byte(eb, 1, 1'b0)), 8'h0F);
        repeat (5) step();

        // 0xFF with Tick every 4th cycle, Tick aligned with the pop cycle
        tick_per = 4;
        while (cyc % 4 != 3) step();
        d0 = dones;
        fifo.push_back(8'hFF);
        wait_for(1, d0 + 1, 1000, "t3_timeout");
        e0 = last_pop + 1;
        check("t3_frame_len", last_done - e0, 640);
        check("t3_no_low_after_start", lows(e0 + 64, last_done, 1'b0), 0);
        check("t3_byte", int'(frame_byte(e0, 4, 1'b0)), 8'hFF);

        // idle with Tick running
        tick_per = 1;
        p0 = pops; d0 = dones; e0 = cyc + 1;
        repeat (100) step();
        check("t4_pops", pops - p0, 0);
        check("t4_dones", dones - d0, 0);
        check("t4_line_high", lows(e0, cyc, 1'b0), 0);

        // reset during bit 3 of 0x00 with a word pending
        p0 = pops; d0 = dones;
        fifo.push_back(8'h00);
        fifo.push_back(8'h5A);
        wait_for(0, p0 + 1, 50, "t5_pop_timeout");
        e0 = last_pop + 1;
        while (cyc < e0 + 72) step();
        rst_next = 1'b0;
        step();
        rst_next = 1'b1;
        step();
        r = cyc;
        check("t5_tx_high", int'(tx), 1);
        check("t5_busy", int'(busy), 0);
        check("t5_no_done", dones - d0, 0);
        check("t5_repop_cycle", last_pop, r);
        check("t5_pops", pops - p0, 2);
        e1 = last_pop + 1;
        wait_for(1, d0 + 1, 400, "t5_done_timeout");
        check("t5_byte", int'(frame_byte(e1, 1, 1'b0)), 8'h5A);

        // two stop bits build, 0x81
        empty32_next = 1'b0;
        wait_for(2, 1, 50, "t6_pop_timeout");
        e0 = last_pop32 + 1;
        wait_for(3, 1, 400, "t6_done_timeout");
        check("t6_stop_ticks", last_done32 - (e0 + 144), 32);
        check("t6_byte", int'(frame_byte(e0, 1, 1'b1)), 8'h81);
        check("t6_stop_high", lows(e0 + 144, last_done32, 1'b1), 0);
        check("t6_pops", pops32, 1);

        // randomized traffic, Tick spacing and resets
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 299) == 0) tick_per = $urandom_range(0, 4);
            if (fifo.size() < 3 && $urandom_range(0, 59) == 0) fifo.push_back(8'($urandom));
            rst_next = ($urandom_range(0, 1499) != 0);
            step();
        end
        rst_next = 1'b1;
        tick_per = 1;
        for (int i = 0; i < 2000 && (m_busy || fifo.size() != 0); i++) step();
        check("drain", int'(m_busy || fifo.size() != 0), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 The block SHALL have parameter DATA_BITS, default 8, meaning data bits per frame (legal range 5..8).
REQ-002 The block SHALL have parameter STOP_TICKS, default 16, meaning Tick pulses per stop period (16 = 1 stop bit, 32 = 2 stop bits).
REQ-003 The block SHALL have port Clock, input, 1 bit, the system clock; all state updates on its rising edge.
REQ-004 The block SHALL have port ResetN, input, 1 bit, synchronous active-low reset.
REQ-005 The block SHALL have port Tick, input, 1 bit, single-cycle baud x16 oversampling strobe.
REQ-006 The block SHALL have port FifoEmpty, input, 1 bit, TX FIFO empty flag.
REQ-007 The block SHALL have port FifoData, input, DATA_BITS bits, TX FIFO head word, valid whenever FifoEmpty=0 (show-ahead read).
REQ-008 The block SHALL have port FifoRead, output, 1 bit, single-cycle pop strobe to the TX FIFO.
REQ-009 The block SHALL have port Tx, output, 1 bit, serial line, registered, idle high.
REQ-010 The block SHALL have port Busy, output, 1 bit, high in every state except IDLE.
REQ-011 The block SHALL have port Done, output, 1 bit, single-cycle pulse at frame completion.

Function
REQ-012 The block SHALL implement states IDLE, START, DATA, STOP, with a 4-bit tick counter, a 3-bit bit counter and a DATA_BITS-bit shift register.
REQ-013 In IDLE with FifoEmpty=0, the block SHALL assert FifoRead for exactly one cycle, load FifoData into the shift register, clear the tick counter and enter START on the next edge.
REQ-014 FifoRead SHALL be asserted only in IDLE with FifoEmpty=0 and never while Busy=1, so at most one pop occurs per frame.
REQ-015 Tx SHALL be registered and change on the same edge as the state: 1 in IDLE and STOP, 0 in START, shift register bit 0 in DATA.
REQ-016 In START, the block SHALL count Tick pulses; on the 16th Tick it SHALL clear the tick counter and bit counter and enter DATA.
REQ-017 In DATA, on each 16th Tick the block SHALL shift the register right by one (LSB transmitted first); after bit index DATA_BITS-1 completes it SHALL enter STOP, otherwise increment the bit counter.
REQ-018 In STOP, after STOP_TICKS Tick pulses the block SHALL pulse Done for one cycle and enter IDLE; the tick counter for STOP SHALL be wide enough for STOP_TICKS=32.
REQ-019 Cycles without Tick SHALL hold all state, counters and Tx.
REQ-020 Back-to-back frames: if FifoEmpty=0 in the IDLE cycle following Done, the next pop SHALL occur in that cycle, giving exactly one idle-high clock between the stop period and the next start bit.
REQ-021 FifoEmpty or FifoData changes during START, DATA or STOP SHALL NOT affect the frame in progress.
REQ-022 Tick arriving in the same cycle as FifoRead SHALL NOT be counted toward START.

Reset
REQ-023 While ResetN=0 at a rising edge, the block SHALL enter IDLE, clear all counters and the shift register, and set Tx=1, FifoRead=0, Busy=0, Done=0.
REQ-024 Reset asserted mid-frame SHALL abort the frame without a Done pulse or an extra pop; the line SHALL be high from the next edge.

Verification
REQ-025 Tick every cycle, push 0x55 -> FifoRead one pulse; Tx=0 for 16 cycles, then 1,0,1,0,1,0,1,0 with 16 cycles each, then 1 for 16 cycles; Done at cycle 160 after the pop; Busy=1 throughout.
REQ-026 FIFO holds 0xA3 and 0x0F, Tick every cycle -> two frames, LSB-first bits 1,1,0,0,0,1,0,1 then 1,1,1,1,0,0,0,0; exactly one idle-high cycle between frames; exactly two FifoRead pulses.
REQ-027 Tick every 4th cycle, push 0xFF -> each bit lasts 64 clocks; frame length 640 clocks; Tx never low after the start bit.
REQ-028 FifoEmpty=1 for 100 cycles with Tick running -> FifoRead=0, Tx=1, Busy=0, Done=0 throughout.
REQ-029 ResetN=0 for one cycle during bit 3 of a 0x00 frame -> Tx=1 on the next edge, Busy=0, no Done; a pending FIFO word is popped only after ResetN returns to 1.
REQ-030 STOP_TICKS=32 build, push 0x81 -> stop period is 32 Ticks; Done occurs 32 Ticks after the last data bit.
